// File: rtl/def.sv
// Opcodes, FSM states and datapath select encodings
// shared by the multicycle controller and its users.
package def;

  localparam logic [5:0] rType = 6'h00;
  localparam logic [5:0] lType = 6'h23;
  localparam logic [5:0] sType = 6'h2B;
  localparam logic [5:0] bType = 6'h04;
  localparam logic [5:0] jType = 6'h02;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10
  } ctrlState;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/param.sv
// Shared build parameters for the multicycle controller.
`ifndef WIDTH
`define WIDTH 8
`endif

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with a
// retired-instruction counter.
`ifndef WIDTH
`define WIDTH 8
`endif

module multicycle_ctrl
  import def::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        opCode,
  input  logic              zero,
  input  logic              memReady,
  output logic              pcWrite,
  output logic              pcWriteCond,
  output logic              iorD,
  output logic              memRead,
  output logic              memWrite,
  output logic              irWrite,
  output logic              memToReg,
  output logic              regDst,
  output logic              regWrite,
  output logic              aluSrcA,
  output logic [1:0]        aluSrcB,
  output logic [1:0]        aluOp,
  output logic [1:0]        pcSrc,
  output logic              illegal,
  output logic [`WIDTH-1:0] instrCount
);

  ctrlState          state_q, state_d;
  logic [`WIDTH-1:0] cnt_q, cnt_d;
  logic              retire;

  // Branch resolution happens in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      IDLE:   if (start) state_d = FETCH;
      FETCH:  if (memReady) state_d = DECODE;
      DECODE: begin
        unique case (opCode)
          lType, sType: state_d = MEM_ADDR;
          rType:        state_d = EXEC_R;
          bType:        state_d = BRANCH;
          jType:        state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEM_ADDR: state_d = (opCode == sType) ? MEM_WR : MEM_RD;
      MEM_RD:   if (memReady) state_d = MEM_WB;
      MEM_WR: begin
        if (memReady) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXEC_R: state_d = R_WB;
      MEM_WB, R_WB, BRANCH, JUMP: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
  end

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_REGB;
    aluOp       = ALU_ADD;
    pcSrc       = PC_ALU;
    illegal     = 1'b0;
    unique case (state_q)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
      end
      DECODE: begin
        aluSrcB = SRCB_BOFF;
        illegal = !(opCode inside {rType, lType, sType, bType, jType});
      end
      MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_SEXT;
      end
      MEM_RD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      MEM_WB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      MEM_WR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      EXEC_R: begin
        aluSrcA = 1'b1;
        aluOp   = ALU_FUNC;
      end
      R_WB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSrc       = PC_ALUOUT;
      end
      JUMP: begin
        pcWrite = 1'b1;
        pcSrc   = PC_JUMP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven check of the multicycle
// controller, plus reset and stall sequences.
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pw;
    logic       pwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic [1:0] psrc;
    logic       ill;
  } outs_t;

  typedef struct {
    logic       start;
    logic [5:0] op;
    logic       z;
    logic       mr;
    outs_t      exp;
    int         cnt;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [5:0]        opCode;
  logic              zero;
  logic              memReady;
  logic              pcWrite, pcWriteCond, iorD, memRead;
  logic              memWrite, irWrite, memToReg, regDst;
  logic              regWrite, aluSrcA, illegal;
  logic [1:0]        aluSrcB, aluOp, pcSrc;
  logic [`WIDTH-1:0] instrCount;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .opCode(opCode), .zero(zero),
    .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
    .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regDst(regDst),
    .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSrc(pcSrc), .illegal(illegal),
    .instrCount(instrCount)
  );

  function automatic outs_t o(
    input logic pw, pwc, iord, mrd, mwr, irw,
    input logic m2r, rdst, rw, asa,
    input logic [1:0] asb, aop, psrc,
    input logic ill
  );
    return '{pw, pwc, iord, mrd, mwr, irw, m2r,
             rdst, rw, asa, asb, aop, psrc, ill};
  endfunction

  function automatic outs_t got();
    return '{pcWrite, pcWriteCond, iorD, memRead,
             memWrite, irWrite, memToReg, regDst,
             regWrite, aluSrcA, aluSrcB, aluOp,
             pcSrc, illegal};
  endfunction

  task automatic chk_o(input string nm, input outs_t e);
    outs_t g;
    g = got();
    checks++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s: outputs got %h want %h",
               nm, g, e);
    end
  endtask

  task automatic chk_c(input string nm, input int e);
    checks++;
    if (instrCount !== e[`WIDTH-1:0]) begin
      fails++;
      $display("FAIL %s: instrCount got %0d want %0d",
               nm, instrCount, e);
    end
  endtask

  outs_t E_IDLE, E_F1, E_F0, E_DEC, E_ILL, E_MA;
  outs_t E_MRD, E_MWB, E_MWR, E_EX, E_RWB, E_BR, E_J;

  vec_t tbl[$];

  initial begin
    E_IDLE = o(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    E_F1   = o(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    E_F0   = o(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    E_DEC  = o(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    E_ILL  = o(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    E_MA   = o(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    E_MRD  = o(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    E_MWB  = o(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    E_MWR  = o(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    E_EX   = o(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    E_RWB  = o(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
    E_BR   = o(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    E_J    = o(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);

    // start, op, zero, memReady, expected, count
    tbl.push_back('{0, 6'h00, 0, 1, E_IDLE, 0});
    tbl.push_back('{1, 6'h00, 0, 1, E_IDLE, 0});
    tbl.push_back('{0, 6'h00, 0, 1, E_F1,   0});
    tbl.push_back('{0, 6'h00, 0, 1, E_DEC,  0});
    tbl.push_back('{0, 6'h00, 0, 1, E_EX,   0});
    tbl.push_back('{0, 6'h00, 0, 1, E_RWB,  0});
    tbl.push_back('{0, 6'h23, 0, 1, E_F1,   1});
    tbl.push_back('{0, 6'h23, 0, 1, E_DEC,  1});
    tbl.push_back('{0, 6'h23, 0, 1, E_MA,   1});
    tbl.push_back('{0, 6'h23, 0, 0, E_MRD,  1});
    tbl.push_back('{0, 6'h23, 0, 0, E_MRD,  1});
    tbl.push_back('{0, 6'h23, 0, 0, E_MRD,  1});
    tbl.push_back('{0, 6'h23, 0, 1, E_MRD,  1});
    tbl.push_back('{0, 6'h23, 0, 1, E_MWB,  1});
    tbl.push_back('{0, 6'h2B, 0, 0, E_F0,   2});
    tbl.push_back('{0, 6'h2B, 0, 1, E_F1,   2});
    tbl.push_back('{0, 6'h2B, 0, 1, E_DEC,  2});
    tbl.push_back('{0, 6'h2B, 0, 1, E_MA,   2});
    tbl.push_back('{0, 6'h2B, 0, 1, E_MWR,  2});
    tbl.push_back('{0, 6'h3F, 0, 1, E_F1,   3});
    tbl.push_back('{0, 6'h3F, 0, 1, E_ILL,  3});
    tbl.push_back('{0, 6'h04, 0, 1, E_F1,   3});
    tbl.push_back('{0, 6'h04, 1, 1, E_DEC,  3});
    tbl.push_back('{0, 6'h04, 1, 1, E_BR,   3});
    tbl.push_back('{0, 6'h02, 0, 1, E_F1,   4});
    tbl.push_back('{0, 6'h02, 0, 1, E_DEC,  4});
    tbl.push_back('{0, 6'h02, 0, 1, E_J,    4});
    tbl.push_back('{1, 6'h00, 0, 1, E_F1,   5});
    tbl.push_back('{1, 6'h00, 0, 1, E_DEC,  5});
    tbl.push_back('{0, 6'h00, 0, 1, E_EX,   5});
    tbl.push_back('{0, 6'h2B, 0, 1, E_RWB,  5});
    tbl.push_back('{0, 6'h2B, 0, 1, E_F1,   6});
    tbl.push_back('{0, 6'h2B, 0, 1, E_DEC,  6});
    tbl.push_back('{0, 6'h2B, 0, 0, E_MA,   6});
    tbl.push_back('{0, 6'h2B, 0, 0, E_MWR,  6});
    tbl.push_back('{0, 6'h2B, 0, 0, E_MWR,  6});

    rst = 1'b0; start = 1'b0; opCode = 6'h00;
    zero = 1'b0; memReady = 1'b1;
    #12;
    chk_o("reset_outs", E_IDLE);
    chk_c("reset_cnt", 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      start    = tbl[i].start;
      opCode   = tbl[i].op;
      zero     = tbl[i].z;
      memReady = tbl[i].mr;
      #2;
      chk_o($sformatf("vec%0d_outs", i), tbl[i].exp);
      chk_c($sformatf("vec%0d_cnt", i), tbl[i].cnt);
    end

    // Asynchronous reset while a store is stalled.
    #1 rst = 1'b0;
    #1;
    chk_o("rst_mid_wr_outs", E_IDLE);
    chk_c("rst_mid_wr_cnt", 0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; memReady = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk_o("idle_hold_outs", E_IDLE);
    chk_c("idle_hold_cnt", 0);

    // Restart and check a fetch stall holds strobes.
    start = 1'b1; memReady = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk_o($sformatf("fetch_stall%0d", k), E_F0);
      @(negedge clk);
    end
    memReady = 1'b1;
    #2;
    chk_o("fetch_go", E_F1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
